// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter between N_REQ requesters: grant, clear, issue len increments, confirm, done.
// Optional WAIT watchdog with sticky err_o is built when COUNTER_SCHED_WDOG_EN is defined.
module counter_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] len_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   cnt_clr_n_o,
  output logic                   num_o,
  input  logic [CNT_W-1:0]       cnt_i,
  input  logic                   of_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               num_q;
  logic               clr_n_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   issue_q;
  logic [CNT_W-1:0]   issue_d;

  logic               sel_found_d;
  logic [IDX_W-1:0]   sel_idx_d;
  logic [IDX_W-1:0]   cand_d;
  logic [CNT_W-1:0]   sel_len_d;
  logic [N_REQ-1:0]   sel_gnt_d;
  logic               wait_hit_d;

`ifdef COUNTER_SCHED_WDOG_EN
  logic [4:0]         wdog_q;
  logic               err_q;
`endif

  function automatic int wrap_idx(input int v);
    return (v >= N_REQ) ? v - N_REQ : v;
  endfunction

  // Search upward from ptr+1 so the last-served requester is considered last.
  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = '0;
    cand_d      = '0;
    sel_len_d   = '0;
    sel_gnt_d   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_d = IDX_W'(wrap_idx(int'(ptr_q) + i));
      if (!sel_found_d && req_i[cand_d]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand_d;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (sel_idx_d == IDX_W'(j)) begin
        sel_len_d    = len_i[j*CNT_W +: CNT_W];
        sel_gnt_d[j] = 1'b1;
      end
    end
  end

  assign issue_d    = issue_q + 1'b1;
  assign wait_hit_d = (cnt_i == len_q) || of_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      num_q   <= 1'b0;
      clr_n_q <= 1'b1;
      ptr_q   <= IDX_W'(N_REQ - 1);
      len_q   <= '0;
      issue_q <= '0;
`ifdef COUNTER_SCHED_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (sel_found_d) begin
            gnt_q   <= sel_gnt_d;
            len_q   <= sel_len_d;
            ptr_q   <= sel_idx_d;
            issue_q <= '0;
            clr_n_q <= 1'b0;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_n_q <= 1'b1;
          if (len_q != '0) begin
            num_q   <= 1'b1;
            state_q <= S_RUN;
          end else begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_RUN: begin
          issue_q <= issue_d;
          if (issue_d == len_q) begin
            num_q   <= 1'b0;
            state_q <= S_WAIT;
`ifdef COUNTER_SCHED_WDOG_EN
            wdog_q  <= '0;
`endif
          end
        end
        // The counter output trails the last strobe by a cycle; wait for it to catch up.
        S_WAIT: begin
          if (wait_hit_d) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= S_DONE;
          end
`ifdef COUNTER_SCHED_WDOG_EN
          else if (wdog_q == 5'd15) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            wdog_q  <= wdog_q + 5'd1;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign num_o       = num_q;
  assign cnt_clr_n_o = clr_n_q;
  assign busy_o      = (state_q != S_IDLE);

`ifdef COUNTER_SCHED_WDOG_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
